// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-way round-robin packet arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Team 4:1 data-select mux, purely combinational.
module mux_4_1
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  sel_t         sel,
  output logic [W-1:0] y
);

  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with packet lock and a single registered
// output stage; in_ready is combinational from state and out_ready.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] in_valid,
  input  logic [N_REQ-1:0] in_last,
  input  logic [W-1:0]     in_data0,
  input  logic [W-1:0]     in_data1,
  input  logic [W-1:0]     in_data2,
  input  logic [W-1:0]     in_data3,
  output logic [N_REQ-1:0] in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output sel_t             out_sel,
  output logic             out_last,
  input  logic             out_ready
);

  state_t      state;
  sel_t        ptr;
  sel_t        lock_sel;
  sel_t        rr_grant;
  sel_t        grant;
  logic        rr_found;
  logic        load_en;
  logic        xfer;
  logic [W-1:0] mux_data;

  assign load_en = !out_valid || out_ready;

  // Round-robin search starting just after the last packet's owner.
  always_comb begin
    sel_t cand;
    cand     = ptr;
    rr_grant = ptr + sel_t'(1);
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ptr + sel_t'(k);
      if (!rr_found && in_valid[cand]) begin
        rr_grant = cand;
        rr_found = 1'b1;
      end
    end
  end

  // Gating on rst_n keeps in_ready low for the whole reset assertion.
  always_comb begin
    grant    = (state == LOCK) ? lock_sel : rr_grant;
    in_ready = '0;
    if (rst_n && load_en && ((state == LOCK) || rr_found)) begin
      in_ready[grant] = 1'b1;
    end
    xfer = in_valid[grant] && in_ready[grant];
  end

  mux_4_1 #(
    .W (W)
  ) u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (grant),
    .y   (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= sel_t'(3);
      lock_sel  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_sel   <= grant;
        out_last  <= in_last[grant];
        if (in_last[grant]) begin
          state <= IDLE;
          ptr   <= grant;
        end else begin
          state    <= LOCK;
          lock_sel <= grant;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
